// File: rtl/fifo_pkg.sv
// Shared defaults and types for the FIFO read-side word packer.
// Holds lane/word sizing and the accumulator fill-state encoding.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PACK       = 4;
    localparam int DEF_TIMEOUT    = 16;

    localparam int CNT_W = $clog2(DEF_PACK + 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Fill state of an accumulator holding c of p lanes.
    function automatic state_e state_of(int c, int p);
        if (c == 0) begin
            return ST_EMPTY;
        end
        if (c >= p) begin
            return ST_FULL;
        end
        return ST_FILL;
    endfunction

endpackage

// File: rtl/fifo_word_packer_idle_timer.sv
// Saturating idle counter for the word packer.
// Raises due once TIMEOUT enabled cycles pass without a clear.
module idle_timer
    import fifo_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic due
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] TERM = W'(TIMEOUT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over count; stop at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != TERM)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign due = (count_q == TERM);

endmodule

// File: rtl/fifo_word_packer.sv
// Packs PACK FIFO lanes into one word on a valid/ready output.
// Partial words are flushed with a keep mask after an idle timeout.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK       = DEF_PACK,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic                       empty,
    input  logic [DATA_WIDTH-1:0]      dout,
    output logic                       r_en,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int CW = $clog2(PACK + 1);
    localparam logic [CW:0] LIMIT = (CW+1)'(PACK);

    logic [PACK-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            inflight_q;
    state_e                          state_q, state_d;
    logic [DATA_WIDTH*PACK-1:0]      out_data_q, out_data_d;
    logic [PACK-1:0]                 out_keep_q, out_keep_d;
    logic                            out_valid_q, out_valid_d;

    logic          free, flush, xfer, due;
    logic          tmr_en, tmr_clr;
    logic [CW-1:0] eff_cnt;
    logic [CW:0]   demand;

    // Transfer decision and pop request; no dependence on dout.
    always_comb begin
        free    = !out_valid_q || out_ready;
        flush   = due && (state_q == ST_FILL);
        xfer    = free && ((state_q == ST_FULL) || flush);
        eff_cnt = xfer ? '0 : cnt_q;
        demand  = {1'b0, eff_cnt} + {{CW{1'b0}}, inflight_q};
        r_en    = !rrst && !empty && (demand < LIMIT);
        tmr_en  = (state_q == ST_FILL) && !inflight_q;
        tmr_clr = inflight_q || xfer || (state_q == ST_EMPTY);
    end

    // Accumulator: empty on transfer, landing byte goes to lane eff_cnt.
    always_comb begin
        acc_d = acc_q;
        cnt_d = eff_cnt;
        if (xfer) begin
            acc_d = '0;
        end
        if (inflight_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (eff_cnt == CW'(i)) begin
                    acc_d[i] = dout;
                end
            end
            cnt_d = eff_cnt + CW'(1);
        end
        state_d = state_of(int'(cnt_d), PACK);
    end

    // Output register: load masked lanes on transfer, hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < PACK; i++) begin
                out_keep_d[i] = (CW'(i) < cnt_q);
                out_data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                    out_keep_d[i] ? acc_q[i] : '0;
            end
        end
    end

    // All packer state; reset drops any partial word and in-flight byte.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            inflight_q  <= r_en;
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
        end
    end

    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk (rclk),
        .rst (rrst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .due (due)
    );

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;

endmodule
